// File: rtl/alu_seq_lab_pkg.sv
// rtl/alu_seq_lab_pkg.sv - shared encodings for the sequential ALU lab top
package alu_seq_lab_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_NOR = 3'b011,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101,
        OP_SLT = 3'b110,
        OP_SLL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_LOAD_A = 2'd0,
        ST_LOAD_B = 2'd1,
        ST_EXEC   = 2'd2,
        ST_SHOW   = 2'd3
    } state_e;

    localparam logic [2:0] SEL_PROGRESS = 3'd6;
    localparam logic [2:0] SEL_FLAGS    = 3'd7;

    // Field order matches the low nibble of the flag word on the LEDs.
    typedef struct packed {
        logic zf;
        logic of;
        logic cf;
        logic nf;
    } flags_t;

endpackage

// File: rtl/alu_seq_lab_alu_core.sv
// rtl/alu_seq_lab_alu_core.sv - combinational ALU with zero/overflow/carry/negative flags
module alu_core
    import alu_seq_lab_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    output logic [WIDTH-1:0] o_f,
    output logic             o_zf,
    output logic             o_of,
    output logic             o_cf,
    output logic             o_nf
);

    localparam int SH = $clog2(WIDTH);

    alu_op_e          w_op;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_slt;
    logic [SH-1:0]    w_shamt;

    assign w_op    = alu_op_e'(i_op);
    assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
    // The extra top bit of the difference is the unsigned borrow.
    assign w_diff  = {1'b0, i_a} - {1'b0, i_b};
    assign w_slt   = $signed(i_a) < $signed(i_b);
    assign w_shamt = i_b[SH-1:0];

    always_comb begin
        o_f  = '0;
        o_cf = 1'b0;
        o_of = 1'b0;
        case (w_op)
            OP_AND: o_f = i_a & i_b;
            OP_OR:  o_f = i_a | i_b;
            OP_XOR: o_f = i_a ^ i_b;
            OP_NOR: o_f = ~(i_a | i_b);
            OP_ADD: begin
                o_f  = w_sum[WIDTH-1:0];
                o_cf = w_sum[WIDTH];
                o_of = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                o_f  = w_diff[WIDTH-1:0];
                o_cf = w_diff[WIDTH];
                o_of = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SLT: o_f = {{(WIDTH-1){1'b0}}, w_slt};
            OP_SLL: o_f = i_a << w_shamt;
            default: o_f = '0;
        endcase
    end

    assign o_zf = (o_f == '0);
    assign o_nf = o_f[WIDTH-1];

endmodule

// File: rtl/alu_seq_lab.sv
// rtl/alu_seq_lab.sv - byte-keyed operand entry, sequential ALU control and LED display
module alu_seq_lab
    import alu_seq_lab_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEB_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] ALU_OP,
    input  logic [7:0] SW,
    input  logic       BTN_LOAD,
    input  logic [2:0] LED_SEL,
    output logic [7:0] LED,
    output logic       DONE
);

    localparam int NB = WIDTH / 8;
    localparam int DW = $clog2(DEB_CYCLES + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [DW-1:0]    r_deb;
    logic             w_ld;

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_f;
    flags_t           r_flags;
    logic [3:0]       r_cnt;
    logic             r_done;

    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;
    logic [WIDTH-1:0] w_f;
    flags_t           w_flags;
    logic [7:0]       w_led;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= '0;
        end else begin
            r_sync1 <= BTN_LOAD;
            r_sync2 <= r_sync1;
            // Saturating at DEB_CYCLES keeps a held button from re-firing.
            if (!r_sync2)
                r_deb <= '0;
            else if (r_deb != DW'(DEB_CYCLES))
                r_deb <= r_deb + 1'b1;
        end
    end

    assign w_ld = r_sync2 && (r_deb == DW'(DEB_CYCLES - 1));

    generate
        if (WIDTH == 8) begin : g_shift_narrow
            assign w_a_next = SW;
            assign w_b_next = SW;
        end else begin : g_shift_wide
            assign w_a_next = {r_a[WIDTH-9:0], SW};
            assign w_b_next = {r_b[WIDTH-9:0], SW};
        end
    endgenerate

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .i_a  (r_a),
        .i_b  (r_b),
        .i_op (ALU_OP),
        .o_f  (w_f),
        .o_zf (w_flags.zf),
        .o_of (w_flags.of),
        .o_cf (w_flags.cf),
        .o_nf (w_flags.nf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD_A;
            r_a     <= '0;
            r_b     <= '0;
            r_f     <= '0;
            r_flags <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD_A: begin
                    if (w_ld) begin
                        r_a <= w_a_next;
                        if (r_cnt == 4'(NB - 1)) begin
                            r_cnt   <= '0;
                            r_state <= ST_LOAD_B;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (w_ld) begin
                        r_b <= w_b_next;
                        if (r_cnt == 4'(NB - 1)) begin
                            r_cnt   <= '0;
                            r_state <= ST_EXEC;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    r_f     <= w_f;
                    r_flags <= w_flags;
                    r_done  <= 1'b1;
                    r_state <= ST_SHOW;
                end
                ST_SHOW: begin
                    // Result tracks ALU_OP live until the next entry begins.
                    if (w_ld) begin
                        r_a     <= '0;
                        r_b     <= '0;
                        r_cnt   <= '0;
                        r_done  <= 1'b0;
                        r_state <= ST_LOAD_A;
                    end else begin
                        r_f     <= w_f;
                        r_flags <= w_flags;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= ST_LOAD_A;
                end
            endcase
        end
    end

    always_comb begin
        w_led = 8'h00;
        case (LED_SEL)
            SEL_PROGRESS: w_led = {r_state, 2'b00, r_cnt};
            SEL_FLAGS:    w_led = {4'b0000, r_flags};
            default: begin
                for (int n = 0; n < NB; n++) begin
                    if (LED_SEL == 3'(n))
                        w_led = r_f[8*n +: 8];
                end
            end
        endcase
    end

    assign LED  = w_led;
    assign DONE = r_done;

endmodule

// File: tb/tb_alu_seq_lab.sv
// tb/tb_alu_seq_lab.sv - randomized self-checking bench for 32-bit and 8-bit builds
module tb_alu_seq_lab;
    import alu_seq_lab_pkg::*;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] op32, sel32, op8, sel8;
    logic [7:0] sw32, sw8, led32, led8;
    logic       btn32, btn8, done32, done8;

    int n_cmp = 0;
    int n_bad = 0;

    always #10 clk = ~clk;

    alu_seq_lab #(.WIDTH(32), .DEB_CYCLES(DEB)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .ALU_OP(op32), .SW(sw32), .BTN_LOAD(btn32),
        .LED_SEL(sel32), .LED(led32), .DONE(done32)
    );

    alu_seq_lab #(.WIDTH(8), .DEB_CYCLES(DEB)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .ALU_OP(op8), .SW(sw8), .BTN_LOAD(btn8),
        .LED_SEL(sel8), .LED(led8), .DONE(done8)
    );

    function automatic logic [7:0] get_led(input bit w8);
        return w8 ? led8 : led32;
    endfunction

    function automatic logic get_done(input bit w8);
        return w8 ? done8 : done32;
    endfunction

    task automatic set_sel(input bit w8, input logic [2:0] s);
        if (w8) sel8 = s; else sel32 = s;
        #1;
    endtask

    task automatic set_op(input bit w8, input logic [2:0] o);
        if (w8) op8 = o; else op32 = o;
    endtask

    task automatic set_btn(input bit w8, input logic v);
        if (w8) btn8 = v; else btn32 = v;
    endtask

    // Reference: plain integer arithmetic on the mathematical values.
    function automatic void model(input int w, input int op, input longint unsigned a,
                                  input longint unsigned b, output longint unsigned f,
                                  output logic [7:0] fl);
        longint unsigned one, mask;
        longint sa, sb, s, smax, smin;
        logic zf, ovf, cf, nf;
        one  = 1;
        mask = (one << w) - 1;
        smax = longint'(mask >> 1);
        smin = -smax - 1;
        sa   = ((a >> (w - 1)) & 1) != 0 ? longint'(a) - longint'(one << w) : longint'(a);
        sb   = ((b >> (w - 1)) & 1) != 0 ? longint'(b) - longint'(one << w) : longint'(b);
        cf   = 1'b0;
        ovf  = 1'b0;
        case (op)
            0: f = a & b;
            1: f = a | b;
            2: f = a ^ b;
            3: f = ~(a | b) & mask;
            4: begin
                f = (a + b) & mask;
                cf = (a + b) > mask;
                s = sa + sb;
                ovf = (s > smax) || (s < smin);
            end
            5: begin
                f = (a - b) & mask;
                cf = a < b;
                s = sa - sb;
                ovf = (s > smax) || (s < smin);
            end
            6: f = (sa < sb) ? 1 : 0;
            default: f = (a << (b % longint'(w))) & mask;
        endcase
        zf = (f == 0);
        nf = ((f >> (w - 1)) & 1) != 0;
        fl = {4'b0000, zf, ovf, cf, nf};
    endfunction

    task automatic press(input bit w8, input logic [7:0] v);
        if (w8) sw8 = v; else sw32 = v;
        set_btn(w8, 1'b1);
        repeat (DEB + 8) @(negedge clk);
        set_btn(w8, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic enter(input bit w8, input longint unsigned a, input longint unsigned b,
                         input logic [2:0] o, output bit ok);
        int nb;
        nb = w8 ? 1 : 4;
        if (get_done(w8)) press(w8, 8'h00);
        set_op(w8, o);
        for (int i = 0; i < nb; i++) press(w8, 8'((a >> (8 * (nb - 1 - i))) & 64'hFF));
        for (int i = 0; i < nb; i++) press(w8, 8'((b >> (8 * (nb - 1 - i))) & 64'hFF));
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (get_done(w8)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic read_result(input bit w8, output longint unsigned f, output logic [7:0] fl);
        int nb;
        nb = w8 ? 1 : 4;
        f = 0;
        for (int n = 0; n < nb; n++) begin
            set_sel(w8, 3'(n));
            f |= longint'(get_led(w8)) << (8 * n);
        end
        set_sel(w8, SEL_FLAGS);
        fl = get_led(w8);
    endtask

    task automatic test_reset;
        logic [2:0] sels [3];
        sels = '{3'd0, 3'd6, 3'd7};
        rst_n = 1'b0;
        btn32 = 0; btn8 = 0; sw32 = 0; sw8 = 0;
        op32 = OP_ADD; op8 = OP_ADD; sel32 = 0; sel8 = 0;
        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 3; i++) begin
                set_sel(bit'(w), sels[i]);
                n_cmp++;
                if (get_led(bit'(w)) !== 8'h00) begin
                    n_bad++;
                    $display("FAIL reset_led w8=%0d sel=%0d: got %h want 00", w, sels[i], get_led(bit'(w)));
                end
            end
            n_cmp++;
            if (get_done(bit'(w)) !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_done w8=%0d: got %b want 0", w, get_done(bit'(w)));
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_bounce_and_add;
        bit ok;
        longint unsigned f;
        logic [7:0] fl;
        logic [2:0] zsel [3];
        zsel = '{3'd0, 3'd4, 3'd5};
        op32 = OP_ADD;
        sw32 = 8'h7F;
        for (int i = 0; i < 3; i++) begin
            btn32 = ~i[0];
            repeat (2) @(negedge clk);
        end
        btn32 = 1'b1;
        repeat (10) @(negedge clk);
        btn32 = 1'b0;
        repeat (4) @(negedge clk);
        set_sel(0, SEL_PROGRESS);
        n_cmp++;
        if (led32 !== 8'h01) begin
            n_bad++;
            $display("FAIL bounce_progress: got %h want 01", led32);
        end
        for (int i = 0; i < 3; i++) press(0, 8'hFF);
        set_sel(0, SEL_PROGRESS);
        n_cmp++;
        if (led32 !== 8'h40) begin
            n_bad++;
            $display("FAIL progress_load_b: got %h want 40", led32);
        end
        for (int i = 0; i < 3; i++) press(0, 8'h00);
        press(0, 8'h01);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done32) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL add_done: DONE never rose within 20 cycles, want 1");
        end
        read_result(0, f, fl);
        n_cmp++;
        if (f !== 64'h8000_0000 || fl !== 8'b0000_0101) begin
            n_bad++;
            $display("FAIL add_ovf: got F=%h flags=%b want F=80000000 flags=00000101", f, fl);
        end
        set_sel(0, 3'd3);
        n_cmp++;
        if (led32 !== 8'h80) begin
            n_bad++;
            $display("FAIL add_sel3: got %h want 80", led32);
        end
        for (int i = 0; i < 3; i++) begin
            set_sel(0, zsel[i]);
            n_cmp++;
            if (led32 !== 8'h00) begin
                n_bad++;
                $display("FAIL add_sel%0d: got %h want 00", zsel[i], led32);
            end
        end
    endtask

    task automatic test_show_ops;
        bit ok;
        longint unsigned f;
        logic [7:0] fl;
        enter(0, 64'h1, 64'h2, OP_ADD, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL show_done: DONE low, want 1"); end
        op32 = OP_SUB;
        read_result(0, f, fl);
        n_cmp++;
        if (f !== 64'h3) begin
            n_bad++;
            $display("FAIL show_latency: got F=%h before edge want 00000003", f);
        end
        @(negedge clk);
        read_result(0, f, fl);
        n_cmp++;
        if (f !== 64'hFFFF_FFFF || fl !== 8'b0000_0011) begin
            n_bad++;
            $display("FAIL show_sub: got F=%h flags=%b want F=ffffffff flags=00000011", f, fl);
        end
        op32 = OP_SLT;
        @(negedge clk);
        read_result(0, f, fl);
        n_cmp++;
        if (f !== 64'h1 || fl !== 8'h00) begin
            n_bad++;
            $display("FAIL show_slt: got F=%h flags=%b want F=00000001 flags=00000000", f, fl);
        end
        enter(0, 64'h1, 64'h23, OP_SLL, ok);
        read_result(0, f, fl);
        n_cmp++;
        if (!ok || f !== 64'h8 || fl !== 8'h00) begin
            n_bad++;
            $display("FAIL show_sll: got done=%b F=%h flags=%b want done=1 F=00000008 flags=00000000", ok, f, fl);
        end
    endtask

    task automatic test_xor_reload;
        bit ok;
        longint unsigned f;
        logic [7:0] fl;
        enter(0, 64'h1234_5678, 64'h1234_5678, OP_XOR, ok);
        read_result(0, f, fl);
        n_cmp++;
        if (!ok || f !== 64'h0 || fl !== 8'b0000_1000) begin
            n_bad++;
            $display("FAIL xor_zero: got done=%b F=%h flags=%b want done=1 F=0 flags=00001000", ok, f, fl);
        end
        press(0, 8'hAA);
        set_sel(0, SEL_PROGRESS);
        n_cmp++;
        if (led32 !== 8'h00 || done32 !== 1'b0) begin
            n_bad++;
            $display("FAIL reload_state: got progress=%h done=%b want progress=00 done=0", led32, done32);
        end
        read_result(0, f, fl);
        n_cmp++;
        if (f !== 64'h0 || fl !== 8'b0000_1000) begin
            n_bad++;
            $display("FAIL reload_hold: got F=%h flags=%b want F=0 flags=00001000", f, fl);
        end
    endtask

    task automatic test_random;
        bit ok, w8;
        int w, op, op2;
        longint unsigned a, b, f, ef;
        logic [7:0] fl, efl;
        for (int i = 0; i < 8; i++) begin
            w8 = bit'(i % 2);
            w  = w8 ? 8 : 32;
            a  = longint'($urandom()) & ((64'h1 << w) - 1);
            b  = longint'($urandom()) & ((64'h1 << w) - 1);
            op = int'($urandom_range(0, 7));
            enter(w8, a, b, 3'(op), ok);
            model(w, op, a, b, ef, efl);
            read_result(w8, f, fl);
            n_cmp++;
            if (!ok || f !== ef || fl !== efl) begin
                n_bad++;
                $display("FAIL rand_exec w=%0d op=%0d a=%h b=%h: got done=%b F=%h flags=%b want F=%h flags=%b",
                         w, op, a, b, ok, f, fl, ef, efl);
            end
            op2 = int'($urandom_range(0, 7));
            set_op(w8, 3'(op2));
            @(negedge clk);
            model(w, op2, a, b, ef, efl);
            read_result(w8, f, fl);
            n_cmp++;
            if (f !== ef || fl !== efl) begin
                n_bad++;
                $display("FAIL rand_show w=%0d op=%0d a=%h b=%h: got F=%h flags=%b want F=%h flags=%b",
                         w, op2, a, b, f, fl, ef, efl);
            end
        end
    endtask

    task automatic test_async_reset;
        bit ok;
        longint unsigned f, ef;
        logic [7:0] fl, efl;
        enter(0, 64'h5, 64'h6, OP_ADD, ok);
        #4 rst_n = 1'b0;
        #1;
        set_sel(0, 3'd0);
        n_cmp++;
        if (done32 !== 1'b0 || led32 !== 8'h00) begin
            n_bad++;
            $display("FAIL rst_in_show: got done=%b led=%h want done=0 led=00", done32, led32);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op32 = OP_SUB;
        for (int i = 0; i < 4; i++) press(0, 8'hC3);
        press(0, 8'h11);
        press(0, 8'h22);
        set_sel(0, SEL_PROGRESS);
        n_cmp++;
        if (led32 !== 8'h42) begin
            n_bad++;
            $display("FAIL pre_rst_progress: got %h want 42", led32);
        end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (led32 !== 8'h00 || done32 !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_b: got progress=%h done=%b want 00/0", led32, done32);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        enter(0, 64'h89AB_CDEF, 64'h0123_4567, OP_SUB, ok);
        model(32, 5, 64'h89AB_CDEF, 64'h0123_4567, ef, efl);
        read_result(0, f, fl);
        n_cmp++;
        if (!ok || f !== ef || fl !== efl) begin
            n_bad++;
            $display("FAIL post_rst_entry: got done=%b F=%h flags=%b want F=%h flags=%b", ok, f, fl, ef, efl);
        end
    endtask

    task automatic test_width8;
        bit ok;
        longint unsigned f;
        logic [7:0] fl;
        enter(1, 64'hF0, 64'h10, OP_ADD, ok);
        read_result(1, f, fl);
        n_cmp++;
        if (!ok || f !== 64'h0 || fl !== 8'b0000_1010) begin
            n_bad++;
            $display("FAIL w8_add_wrap: got done=%b F=%h flags=%b want F=00 flags=00001010", ok, f, fl);
        end
        enter(1, 64'h7F, 64'h01, OP_ADD, ok);
        read_result(1, f, fl);
        n_cmp++;
        if (!ok || f !== 64'h80 || fl !== 8'b0000_0101) begin
            n_bad++;
            $display("FAIL w8_add_ovf: got done=%b F=%h flags=%b want F=80 flags=00000101", ok, f, fl);
        end
        for (int s = 1; s < 6; s++) begin
            set_sel(1, 3'(s));
            n_cmp++;
            if (led8 !== 8'h00) begin
                n_bad++;
                $display("FAIL w8_sel%0d: got %h want 00", s, led8);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_bounce_and_add();
        test_show_ops();
        test_xor_reload();
        test_random();
        test_async_reset();
        test_width8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
